// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the registered N-input valid/ready arbiter.
package arbiter_pkg;

  // Grant policy: fixed priority (channel 0 highest) or round-robin.
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // Modulo-n increment written as an explicit compare-and-wrap so that it
  // stays correct when n is not a power of two.
  function automatic int rr_next(input int last, input int n);
    if (last + 1 >= n) begin
      return 0;
    end
    return last + 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_reg_picker.sv
// Rotating priority encoder: scans req starting at index 'start', wrapping
// modulo N, and grants the first requester found. Purely combinational.
module priority_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  // Walk the N candidate positions in rotated order; the first hit wins.
  always_comb begin
    int             idx;
    logic [IDW-1:0] sel;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      sel = IDW'(idx);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_reg.sv
// N-input valid/ready arbiter with a registered output stage, a source-id
// tag, and a fixed-priority or round-robin grant policy.
module arbiter_rr_reg
  import arbiter_pkg::*;
#(
  parameter int        N_INPUTS = 4,
  parameter int        DWIDTH   = 8,
  parameter arb_mode_t MODE     = ARB_RR,
  parameter int        IDW      = $clog2(N_INPUTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_INPUTS-1:0]        in_valid,
  input  logic [N_INPUTS*DWIDTH-1:0] in_data,
  output logic [N_INPUTS-1:0]        in_ready,
  output logic                       out_valid,
  output logic [DWIDTH-1:0]          out_data,
  output logic [IDW-1:0]             out_id,
  input  logic                       out_ready
);

  // Most recently transferred channel; reset to N-1 so channel 0 goes first.
  logic [IDW-1:0]      last;
  logic [IDW-1:0]      start;
  logic [N_INPUTS-1:0] gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                any;
  logic                load;
  logic                xfer;
  logic [DWIDTH-1:0]   sel_data;

  // The output register can take a new word when empty or draining now.
  assign load = ~out_valid | out_ready;

  // Round-robin searches from the channel after the last winner; fixed
  // priority always searches from channel 0.
  assign start = (MODE == ARB_RR) ? IDW'(rr_next(int'(last), N_INPUTS)) : '0;

  priority_picker #(
    .N   (N_INPUTS),
    .IDW (IDW)
  ) u_picker (
    .req     (in_valid),
    .start   (start),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Ready is the grant gated by load; nothing is accepted during reset.
  assign in_ready = gnt & {N_INPUTS{load & ~rst}};
  assign xfer     = any & load & ~rst;

  // AND-OR payload mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // ---- stage boundary: input pick -> registered output ----
  // Output register and priority pointer; the pointer moves only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      last      <= IDW'(N_INPUTS - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_id    <= gnt_idx;
        last      <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr_reg.sv
// Bench for arbiter_rr_reg: three instances (N=4 round-robin, N=4 fixed,
// N=3 round-robin) checked every cycle against a behavioural model, plus
// directed sequences with literal expectations.
module tb_arbiter_rr_reg;
  import arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  iv   [3];
  logic [31:0] idat [3];
  logic        ordy [3];

  logic [3:0] ir0, ir1;
  logic [2:0] ir2;
  logic       ov0, ov1, ov2;
  logic [7:0] od0, od1, od2;
  logic [1:0] oid0, oid1, oid2;

  arbiter_rr_reg #(.N_INPUTS(4), .DWIDTH(8), .MODE(ARB_RR)) u_rr4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_id(oid0), .out_ready(ordy[0]));

  arbiter_rr_reg #(.N_INPUTS(4), .DWIDTH(8), .MODE(ARB_FIXED)) u_fx4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_id(oid1), .out_ready(ordy[1]));

  arbiter_rr_reg #(.N_INPUTS(3), .DWIDTH(8), .MODE(ARB_RR)) u_rr3 (
    .clk(clk), .rst(rst), .in_valid(iv[2][2:0]), .in_data(idat[2][23:0]), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_id(oid2), .out_ready(ordy[2]));

  // Behavioural model state per instance.
  int         nin [3] = '{4, 4, 3};
  bit         rrm [3] = '{1'b1, 1'b0, 1'b1};
  int         m_last [3];
  logic       m_ov [3];
  logic [7:0] m_od [3];
  int         m_oid [3];
  logic [3:0] acc [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Winner by the policy rules: rotate from last+1 (mod n) or from 0.
  function automatic int pick(int k);
    int s;
    s = rrm[k] ? (m_last[k] + 1) % nin[k] : 0;
    for (int j = 0; j < nin[k]; j++) begin
      int c;
      c = (s + j) % nin[k];
      if (iv[k][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int k);
    int w;
    w = pick(k);
    if (rst || (m_ov[k] && !ordy[k]) || w < 0) return 4'b0000;
    return 4'b0001 << w;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  // Model advance on each rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int w;
      if (rst) begin
        m_ov[k]   <= 1'b0;
        m_od[k]   <= 8'h00;
        m_oid[k]  <= 0;
        m_last[k] <= nin[k] - 1;
      end else if (!m_ov[k] || ordy[k]) begin
        w = pick(k);
        if (w >= 0) begin
          m_ov[k]   <= 1'b1;
          m_od[k]   <= idat[k][w*8 +: 8];
          m_oid[k]  <= w;
          m_last[k] <= w;
        end else begin
          m_ov[k] <= 1'b0;
        end
      end
    end
  end

  // Compare every output of every instance on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0] er, ar;
        logic       aov;
        logic [7:0] aod;
        logic [1:0] aid;
        if (k == 0) begin
          ar = ir0; aov = ov0; aod = od0; aid = oid0;
        end else if (k == 1) begin
          ar = ir1; aov = ov1; aod = od1; aid = oid1;
        end else begin
          ar = {1'b0, ir2}; aov = ov2; aod = od2; aid = oid2;
        end
        er     = exp_ready(k);
        acc[k] = er & iv[k];
        chk("in_ready", k, 32'(ar), 32'(er));
        chk("out_valid", k, 32'(aov), 32'(m_ov[k]));
        chk("out_data", k, 32'(aod), 32'(m_od[k]));
        chk("out_id", k, 32'(aid), 32'(m_oid[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_ids [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst     = 1'b1;
    iv[0]   = 4'b1111; idat[0] = 32'hA3A2A1A0;
    iv[1]   = 4'b1010; idat[1] = 32'hA3A2A1A0;
    iv[2]   = 4'b0100; idat[2] = 32'h00C2C1C0;
    for (int k = 0; k < 3; k++) begin
      ordy[k] = 1'b1;
      acc[k]  = 4'b0000;
    end

    // Reset held for two cycles with requests present.
    tick();
    chk_en = 1'b1;
    chk("rst_out_valid", 0, 32'(ov0), 32'd0);
    chk("rst_in_ready", 0, 32'(ir0), 32'd0);
    chk("rst_out_data", 0, 32'(od0), 32'd0);
    tick();
    chk("rst_in_ready2", 1, 32'(ir1), 32'd0);
    rst = 1'b0;

    // Round-robin order, fixed priority, and N=3 wrap with sparse requests.
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rr_seq_id", 0, 32'(oid0), 32'(rr_ids[c]));
      chk("rr_seq_data", 0, 32'(od0), 32'(8'hA0 + rr_ids[c]));
      chk("fixed_id", 1, 32'(oid1), (c < 3) ? 32'd1 : 32'd3);
      chk("wrap3_id", 2, 32'(oid2), (c == 0) ? 32'd2 : ((c % 2 == 1) ? 32'd0 : 32'd2));
      if (c == 0) iv[2] = 4'b0101;
      if (c == 2) iv[1] = 4'b1000;
    end

    // Backpressure: load 0x55 from channel 2, then stall for 5 cycles.
    iv[0] = 4'b0100; idat[0] = 32'h00550000;
    tick();
    chk("bp_load_id", 0, 32'(oid0), 32'd2);
    chk("bp_load_data", 0, 32'(od0), 32'h55);
    ordy[0] = 1'b0;
    iv[0]   = 4'b1111; idat[0] = 32'hB3B2B1B0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", 0, 32'(ov0), 32'd1);
      chk("bp_hold_data", 0, 32'(od0), 32'h55);
      chk("bp_hold_id", 0, 32'(oid0), 32'd2);
      chk("bp_hold_ready", 0, 32'(ir0), 32'd0);
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp_release_ready", 0, 32'(ir0), 32'b1000);
    tick();
    chk("bp_next_id", 0, 32'(oid0), 32'd3);
    chk("bp_next_data", 0, 32'(od0), 32'hB3);

    // Reset pulse while channel 1 is being granted.
    tick();
    chk("pre_rst_id", 0, 32'(oid0), 32'd0);
    chk("pre_rst_ready", 0, 32'(ir0), 32'b0010);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 0, 32'(ir0), 32'd0);
    tick();
    chk("post_rst_valid", 0, 32'(ov0), 32'd0);
    chk("post_rst_data", 0, 32'(od0), 32'd0);
    rst = 1'b0;
    tick();
    chk("restart_valid", 0, 32'(ov0), 32'd1);
    chk("restart_id", 0, 32'(oid0), 32'd0);
    chk("restart_data", 0, 32'(od0), 32'hB0);

    // Randomized traffic obeying the hold-while-waiting obligation.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 3; k++) begin
        ordy[k] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < nin[k]; c++) begin
          if (!iv[k][c] || acc[k][c]) begin
            iv[k][c]             = ($urandom_range(0, 2) != 0);
            idat[k][c*8 +: 8]    = 8'($urandom);
          end
        end
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_reg.md
# arbiter_rr_reg

Parametrised N-input valid/ready arbiter with a registered output stage and a selectable fixed-priority or round-robin grant policy. It replaces the two-input combinational fixed-priority arbiter wherever several engine or memory-request streams merge into one consumer. The output register breaks the combinational valid path, and a source-index tag lets downstream logic route responses.

## Interface
- `N_INPUTS`, default 4: number of input channels; must be ≥2.
- `DWIDTH`, default 8: payload width per channel.
- `MODE`, default `ARB_RR`: `ARB_FIXED` makes channel 0 highest priority and N-1 lowest. `ARB_RR` selects round-robin.
- `IDW`, default `$clog2(N_INPUTS)`: width of the source-index tag.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  N_INPUTS  per-channel valid.
- `in_data`  in  N_INPUTS*DWIDTH  packed payloads; channel i occupies bits [i*DWIDTH +: DWIDTH].
- `in_ready`  out  N_INPUTS  per-channel ready. At most one bit is high per cycle.
- `out_valid`  out  1  registered output valid.
- `out_data`  out  DWIDTH  registered payload.
- `out_id`  out  IDW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  downstream ready.

## Operation
- **Output register.** The block has one output register holding `out_valid`, `out_data` and `out_id`.
  - `load = ~out_valid | out_ready`, i.e. the register is empty or is draining this cycle.
- **Grant selection.** `grant` is a one-hot vector computed combinationally from `in_valid` and the priority pointer.
  - `in_ready[i] = grant[i] & load`.
  - A transfer occurs on channel i when `in_valid[i] & in_ready[i]`.
- **On a transfer:**
  - `out_data` ← channel i data.
  - `out_id` ← i.
  - `out_valid` ← 1.
- **When load=1 and no channel is valid:** `out_valid` ← 0. `out_data` and `out_id` hold their previous values.
- **When load=0:** all output registers hold. `out_data` and `out_id` stay stable while `out_valid & ~out_ready`.
- **ARB_FIXED:** the grant goes to the lowest-index valid channel. The pointer is unused.
- **ARB_RR:**
  - The pointer `last` (IDW bits) stores the most recently transferred channel.
  - Search order is `last+1, last+2, …` modulo N_INPUTS, and the first valid channel wins.
  - `last` updates only on a transfer, never on an offered-but-unaccepted grant.
  - Wrap-around: when `last=N_INPUTS-1`, the search starts at 0. The modulo is computed explicitly, so it is correct for non-power-of-two N_INPUTS.
- **Input obligations.** A channel must not drop `in_valid` or change `in_data` while it is waiting. The block does not check this.
- **No valid inputs:** `grant=0` and every `in_ready` is 0.

## Timing
- **Reset values** (synchronous; take effect on the first rising edge with `rst=1`):
  - `out_valid=0`, `out_data=0`, `out_id=0`, `last=N_INPUTS-1`, so channel 0 has first priority after reset.
  - `in_ready` is 0 while `rst` is high.
- **Reset mid-operation:** any pending output is discarded. The upstream transfer in that cycle is not accepted.
- **Latency:** an input accepted at edge k appears at `out_valid` after edge k.
- **Throughput:** one transfer per cycle when `out_ready` is held at 1.
- **Combinational paths:**
  - `out_ready` → `in_ready`: a single AND term.
  - `in_valid` → `in_ready`: through the priority picker.
  - There is no combinational path from `in_*` to `out_*`.
- **Simultaneous events:** when the output drains and a new transfer occurs in the same cycle, the new word replaces the old one with no bubble.
- **Fairness:** with all N channels continuously valid in `ARB_RR` and `out_ready=1`, each channel gets exactly one grant in every N consecutive transfers.

## Structure
- Package `arbiter_pkg` contains:
  - `typedef enum logic {ARB_FIXED=1'b0, ARB_RR=1'b1} arb_mode_t`.
  - Function `rr_next(last, n)`, which returns the modulo-n increment.
- Sub-module `priority_picker`:
  - Combinational rotating priority encoder.
  - Inputs: `req[N]`, `start[IDW]`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx[IDW]`, `any`.
  - `ARB_FIXED` instantiates it with `start` tied to 0.
- Top level contains the output register, the pointer register and the ready gating.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all `in_valid=1`. Expect `out_valid=0`, `in_ready=0`, `out_data=0`. On the first cycle after reset, channel 0 is granted and `out_id=0` the next cycle.
- **Round-robin fairness:** N=4, `ARB_RR`, all channels valid with data `0xA0+i`, `out_ready=1`. The output sequence must be ids 0,1,2,3,0,1 with data A0,A1,A2,A3,A0,A1.
- **Fixed priority:** `ARB_FIXED`, channels 1 and 3 valid. Every cycle grants channel 1. When channel 1 drops, channel 3 is granted the next cycle.
- **Backpressure:** hold `out_ready=0` for 5 cycles with `out_valid=1`, `out_data=0x55`, `out_id=2`. All outputs stay stable, all `in_ready` stay 0, and `last` stays unchanged. Releasing `out_ready` accepts the next channel in the same cycle.
- **Wrap with sparse requests:** N=3 (non-power-of-two), `last=2`, only channel 2 valid. Channel 2 is granted. Then channels 0 and 2 valid: channel 0 is granted, then channel 2.
- **Reset mid-stream:** pulse `rst` for 1 cycle while `out_valid=1` and channel 1 is transferring. `out_valid=0` next cycle, and round-robin restarts from channel 0.
